// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo pulse encoding constants and decoder state encoding
// Purpose: constants shared by the servo pulse driver and decoder so that encode
//          and decode agree, plus the decoder FSM state type.
// Ports:   none (package).
package servo_pkg;

  // clk_50 cycles per pulse-width tick
  localparam int SERVO_TICK_DIV     = 98;
  // ticks of high time that correspond to position 0
  localparam int SERVO_PULSE_OFFSET = 256;
  // width of a position code
  localparam int POS_W              = 8;

  typedef enum logic [1:0] {
    S_WAIT_LOW  = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_MEASURE   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/servo_tick_gen.sv
// rtl/servo_tick_gen.sv - restartable TICK_DIV prescaler
// Purpose: divides clk_50 down to a one-cycle tick every TICK_DIV cycles; a
//          restart forces the count back to 0 so widths are measured from the
//          detected edge.
// Ports:
//   clk_50   in  system clock
//   reset    in  synchronous active-high reset
//   restart  in  clear the prescaler to 0 this cycle
//   tick     out high while the prescaler sits at TICK_DIV-1
module servo_tick_gen import servo_pkg::*; #(
  parameter int TICK_DIV = SERVO_TICK_DIV
) (
  input  logic clk_50,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_50) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rcservo_pulse_decoder.sv
// rtl/rcservo_pulse_decoder.sv - RC servo pulse width to position decoder
// Purpose: measures the high time of a servo PWM pulse in ticks and decodes it
//          to an 8-bit position code (high time = PULSE_OFFSET + position ticks).
//          Optional glitch filter enabled by defining RCSERVO_GLITCH_FILTER_EN.
// Ports:
//   clk_50       in  system clock
//   reset        in  synchronous active-high reset
//   pulse_in     in  asynchronous servo pulse input
//   position     out last decoded position
//   valid        out one-cycle strobe when position updates
//   under_range  out last pulse shorter than PULSE_OFFSET ticks (sticky until next valid)
//   over_range   out last pulse longer than PULSE_OFFSET+255 ticks or stuck high
//   signal_lost  out no rising edge for TIMEOUT_TICKS ticks
module rcservo_pulse_decoder import servo_pkg::*; #(
  parameter int TICK_DIV      = SERVO_TICK_DIV,
  parameter int PULSE_OFFSET  = SERVO_PULSE_OFFSET,
  parameter int MAX_TICKS     = 1023,
  parameter int TIMEOUT_TICKS = 12800,
  parameter int FILTER_LEN    = 3
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [POS_W-1:0] position,
  output logic             valid,
  output logic             under_range,
  output logic             over_range,
  output logic             signal_lost
);

`ifdef RCSERVO_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  localparam int W_W  = $clog2(MAX_TICKS + 1);
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  // cycles after reset before the conditioned input reflects the pin
  localparam int PIPE_DEPTH = 2 + (GLITCH_EN ? FILTER_LEN : 0);
  localparam int PRIME_W    = $clog2(PIPE_DEPTH + 1);

  localparam logic [W_W-1:0]     MAX_W    = W_W'(MAX_TICKS);
  localparam logic [W_W-1:0]     OFFSET_W = W_W'(PULSE_OFFSET);
  localparam logic [W_W-1:0]     HI_W     = W_W'(PULSE_OFFSET + 255);
  localparam logic [TO_W-1:0]    TO_MAX   = TO_W'(TIMEOUT_TICKS);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PIPE_DEPTH);

  logic [1:0] sync_q;
  logic       sig;
  logic       prev_q;
  logic       rise;
  logic       fall;
  logic       tick;

  logic [PRIME_W-1:0] prime_q;
  logic               primed;

  dec_state_t       state_q, state_d;
  logic [W_W-1:0]   width_q, width_d, width_inc;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             under_q, under_d;
  logic             over_q, over_d;
  logic [TO_W-1:0]  to_q;

  // two-flop synchronizer
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pulse_in};
    end
  end

`ifdef RCSERVO_GLITCH_FILTER_EN
  localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

  logic            filt_q;
  logic [FC_W-1:0] fcnt_q;

  // output follows the synced input only after FILTER_LEN consecutive
  // samples that disagree with it
  always_ff @(posedge clk_50) begin
    if (reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FC_LAST) begin
      filt_q <= sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign sig = filt_q;
`else
  assign sig = sync_q[1];
`endif

  // edge detect
  always_ff @(posedge clk_50) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig;
    end
  end

  assign rise = sig & ~prev_q;
  assign fall = ~sig & prev_q;

  // The input pipeline resets to 0, so right after reset sig reads low even
  // if the pin is high. Hold S_WAIT_LOW until the pipeline has refilled so a
  // pulse already in progress at reset release is not mistaken for a new one.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      prime_q <= '0;
    end else if (prime_q != PRIME_DONE) begin
      prime_q <= prime_q + 1'b1;
    end
  end

  assign primed = (prime_q == PRIME_DONE);

  servo_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_50  (clk_50),
    .reset   (reset),
    .restart (rise),
    .tick    (tick)
  );

  // width after counting this cycle's tick (saturating)
  assign width_inc = (tick && (width_q != MAX_W)) ? width_q + 1'b1 : width_q;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= S_WAIT_LOW;
      width_q <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    under_d = under_q;
    over_d  = over_q;

    case (state_q)
      S_WAIT_LOW: begin
        if (primed && !sig) begin
          state_d = S_WAIT_RISE;
        end
      end

      S_WAIT_RISE: begin
        if (rise) begin
          width_d = '0;
          state_d = S_MEASURE;
        end
      end

      S_MEASURE: begin
        width_d = width_inc;
        if (fall) begin
          state_d = S_WAIT_RISE;
          valid_d = 1'b1;
          if (width_inc < OFFSET_W) begin
            pos_d   = '0;
            under_d = 1'b1;
            over_d  = 1'b0;
          end else if (width_inc > HI_W) begin
            pos_d   = '1;
            under_d = 1'b0;
            over_d  = 1'b1;
          end else begin
            pos_d   = POS_W'(width_inc - OFFSET_W);
            under_d = 1'b0;
            over_d  = 1'b0;
          end
        end else if (width_inc == MAX_W) begin
          // stuck high: abandon the pulse and wait for the line to drop
          state_d = S_WAIT_LOW;
          under_d = 1'b0;
          over_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_WAIT_LOW;
      end
    endcase
  end

  // ticks since the last rise, saturating at the timeout
  always_ff @(posedge clk_50) begin
    if (reset || rise) begin
      to_q <= '0;
    end else if (tick && (to_q != TO_MAX)) begin
      to_q <= to_q + 1'b1;
    end
  end

  assign position    = pos_q;
  assign valid       = valid_q;
  assign under_range = under_q;
  assign over_range  = over_q;
  assign signal_lost = (to_q == TO_MAX);

endmodule
